// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared size/state encodings and lane widths for the MEM-stage access unit
package mem_access_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_e;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [1:0]        offset,
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merge_data
);
  logic [BYTE_W-1:0] b;
  logic [HALF_W-1:0] h;
  logic [4:0]        sh;
  logic [WORD_W-1:0] mask;
  // halves use only offset[1]; the lane shift doubles as extract and merge position
  always_comb begin
    sh = (size == SZ_BYTE) ? {offset, 3'b000} : {offset[1], 4'b0000};
    b = BYTE_W'(word >> sh);
    h = HALF_W'(word >> sh);
    load_data = (size == SZ_BYTE) ? (is_unsigned ? WORD_W'(b) : {{(WORD_W-BYTE_W){b[BYTE_W-1]}}, b}) :
                (size == SZ_HALF) ? (is_unsigned ? WORD_W'(h) : {{(WORD_W-HALF_W){h[HALF_W-1]}}, h}) : word;
    mask = ((size == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merge_data = (word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage RAM initiator; loads, word stores, read-merge-write sub-word stores (optional stats via MEM_ACCESS_STATS_EN)
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  output logic                  o_ready,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [ADDR_WIDTH+1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata,
  output logic                  o_rvalid,
  output logic                  o_wdone,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [31:0]           o_ram_data,
  output logic                  o_ram_we,
  input  logic [31:0]           i_ram_data
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [31:0]           o_load_cnt,
  output logic [31:0]           o_store_cnt,
  output logic [31:0]           o_err_cnt
`endif
);
  state_e                state, state_nx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_merge, r_rdata, load_data, merge_data;
  logic                  r_rvalid, r_wdone, r_err;
  logic                  accept, bad, do_load, do_sw, do_sub;

  mem_lane_align u_align (
    .size        (i_size),
    .is_unsigned (i_unsigned),
    .offset      (i_addr[1:0]),
    .word        (i_ram_data),
    .wdata       (i_wdata),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  // decode the accepted request, next state and the RAM-side drive
  always_comb begin
    accept = i_req && (state == ST_IDLE);
    bad = (i_size == SZ_RSVD) || ((i_size == SZ_HALF) && i_addr[0]) ||
          ((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00));
    do_load = accept && !bad && !i_we;
    do_sw = accept && !bad && i_we && (i_size == SZ_WORD);
    do_sub = accept && !bad && i_we && (i_size != SZ_WORD);
    state_nx = do_sub ? ST_WRITE : ST_IDLE;
    o_ready = (state == ST_IDLE);
    o_ram_we = do_sw || (state == ST_WRITE);
    o_ram_addr = (state == ST_IDLE) ? i_addr[ADDR_WIDTH+1:2] : r_addr;
    o_ram_data = (state == ST_WRITE) ? r_merge : do_sw ? i_wdata : '0;
  end

  // state register; reset aborts a pending merge write immediately
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= ST_IDLE;
    else state <= state_nx;

  // registered load data, merge word/address capture and one-cycle status pulses
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_addr <= '0;
      r_merge <= '0;
      r_rdata <= '0;
      r_rvalid <= 1'b0;
      r_wdone <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_rvalid <= do_load;
      r_wdone <= do_sw || (state == ST_WRITE);
      r_err <= accept && bad;
      if (do_load) r_rdata <= load_data;
      if (do_sub) begin
        r_merge <= merge_data;
        r_addr <= i_addr[ADDR_WIDTH+1:2];
      end
    end

  assign o_rdata = r_rdata;
  assign o_rvalid = r_rvalid;
  assign o_wdone = r_wdone;
  assign o_err = r_err;

`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] load_cnt, store_cnt, err_cnt;
  // saturating event counters: loads at accept, stores at commit, errors at the drop pulse
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      load_cnt <= '0;
      store_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (do_load && (load_cnt != '1)) load_cnt <= load_cnt + 32'd1;
      if (r_wdone && (store_cnt != '1)) store_cnt <= store_cnt + 32'd1;
      if (r_err && (err_cnt != '1)) err_cnt <= err_cnt + 32'd1;
    end
  assign o_load_cnt = load_cnt;
  assign o_store_cnt = store_cnt;
  assign o_err_cnt = err_cnt;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit with a behavioural async-read RAM
module tb_mem_access_unit;
  logic        i_clk = 1'b0, i_rst = 1'b1, i_req = 1'b0, i_we = 1'b0, i_unsigned = 1'b0;
  logic [1:0]  i_size = 2'b00;
  logic [9:0]  i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_rdata, o_ram_data, i_ram_data;
  logic        o_ready, o_rvalid, o_wdone, o_err, o_ram_we;
  logic [7:0]  o_ram_addr;
  logic [31:0] mem [0:255];
  int checks = 0, errors = 0, we_cnt = 0, nr_cnt = 0;
`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] o_load_cnt, o_store_cnt, o_err_cnt;
`endif

  mem_access_unit #(.ADDR_WIDTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .o_ready(o_ready), .i_we(i_we),
    .i_size(i_size), .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_wdone(o_wdone), .o_err(o_err),
    .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data), .o_ram_we(o_ram_we), .i_ram_data(i_ram_data)
`ifdef MEM_ACCESS_STATS_EN
    , .o_load_cnt(o_load_cnt), .o_store_cnt(o_store_cnt), .o_err_cnt(o_err_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;
  assign i_ram_data = mem[o_ram_addr];
  always @(posedge i_clk) if (o_ram_we) mem[o_ram_addr] <= o_ram_data;
  always @(posedge i_clk) if (!i_rst) begin
    if (o_ram_we) we_cnt++;
    if (!o_ready) nr_cnt++;
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [9:0] a, input logic [31:0] wd);
    @(negedge i_clk);
    i_req = 1'b1; i_we = we; i_size = sz; i_unsigned = uns; i_addr = a; i_wdata = wd;
    @(posedge i_clk); #1;
    i_req = 1'b0;
  endtask

  task automatic load_chk(input string name, input logic [1:0] sz, input logic uns, input logic [9:0] a, input logic [31:0] exp);
    issue(1'b0, sz, uns, a, 32'h0);
    checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== exp) begin
      errors++;
      $display("FAIL %s rvalid=%b rdata=%h expected rvalid=1 rdata=%h", name, o_rvalid, o_rdata, exp);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if ({o_ready, o_rvalid, o_wdone, o_err, o_ram_we} !== 5'b10000 || o_rdata !== 32'h0 || o_ram_data !== 32'h0) begin
      errors++;
      $display("FAIL reset ready/rvalid/wdone/err/we=%b rdata=%h ram_data=%h expected 10000 0 0",
               {o_ready, o_rvalid, o_wdone, o_err, o_ram_we}, o_rdata, o_ram_data);
    end
    @(negedge i_clk) i_rst = 1'b0;
  endtask

  task automatic test_loads;
    mem[4] = 32'h80FF7F01;
    load_chk("lb_11", 2'b00, 1'b0, 10'h011, 32'h0000007F);
    load_chk("lb_12", 2'b00, 1'b0, 10'h012, 32'hFFFFFFFF);
    load_chk("lbu_13", 2'b00, 1'b1, 10'h013, 32'h00000080);
    load_chk("lh_12", 2'b01, 1'b0, 10'h012, 32'hFFFF80FF);
    load_chk("lhu_10", 2'b01, 1'b1, 10'h010, 32'h00007F01);
    @(posedge i_clk); #1;
    checks++;
    if (o_rvalid !== 1'b0 || o_rdata !== 32'h00007F01) begin
      errors++;
      $display("FAIL rvalid_pulse rvalid=%b rdata=%h expected rvalid=0 rdata held 00007f01", o_rvalid, o_rdata);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge i_clk);
    i_req = 1'b1; i_we = 1'b0; i_size = 2'b00; i_unsigned = 1'b0; i_addr = 10'h011;
    @(posedge i_clk); #1;
    checks++;
    if (o_rdata !== 32'h0000007F || o_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first rdata=%h rvalid=%b expected 0000007f 1", o_rdata, o_rvalid);
    end
    i_addr = 10'h013; i_unsigned = 1'b1;
    @(posedge i_clk); #1;
    i_req = 1'b0;
    checks++;
    if (o_rdata !== 32'h00000080 || o_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second rdata=%h rvalid=%b expected 00000080 1", o_rdata, o_rvalid);
    end
  endtask

  task automatic test_sw;
    we_cnt = 0; nr_cnt = 0;
    issue(1'b1, 2'b10, 1'b0, 10'h020, 32'hDEADBEEF);
    checks++;
    if (o_wdone !== 1'b1 || mem[8] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_commit wdone=%b mem=%h expected 1 deadbeef", o_wdone, mem[8]);
    end
    load_chk("lw_20", 2'b10, 1'b0, 10'h020, 32'hDEADBEEF);
    checks++;
    if (we_cnt !== 1 || nr_cnt !== 0) begin
      errors++;
      $display("FAIL sw_timing we_cycles=%0d notready_cycles=%0d expected 1 0", we_cnt, nr_cnt);
    end
  endtask

  task automatic test_subword;
    mem[12] = 32'h11223344;
    nr_cnt = 0;
    issue(1'b1, 2'b00, 1'b0, 10'h031, 32'h123456AA);
    checks++;
    if (o_ready !== 1'b0 || o_ram_we !== 1'b1 || o_ram_addr !== 8'h0C || o_ram_data !== 32'h1122AA44 || o_wdone !== 1'b0) begin
      errors++;
      $display("FAIL sb_write ready=%b we=%b addr=%h data=%h wdone=%b expected 0 1 0c 1122aa44 0",
               o_ready, o_ram_we, o_ram_addr, o_ram_data, o_wdone);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_wdone !== 1'b1 || o_ready !== 1'b1 || o_ram_we !== 1'b0 || mem[12] !== 32'h1122AA44) begin
      errors++;
      $display("FAIL sb_done wdone=%b ready=%b we=%b mem=%h expected 1 1 0 1122aa44", o_wdone, o_ready, o_ram_we, mem[12]);
    end
    load_chk("lw_30_after_sb", 2'b10, 1'b0, 10'h030, 32'h1122AA44);
    issue(1'b1, 2'b01, 1'b0, 10'h032, 32'h1234BEEF);
    @(posedge i_clk); #1;
    load_chk("lw_30_after_sh", 2'b10, 1'b0, 10'h030, 32'hBEEFAA44);
    checks++;
    if (nr_cnt !== 2) begin
      errors++;
      $display("FAIL subword_occupancy notready_cycles=%0d expected 2", nr_cnt);
    end
  endtask

  task automatic test_errors;
    we_cnt = 0;
    issue(1'b0, 2'b10, 1'b0, 10'h022, 32'h0);
    checks++;
    if (o_err !== 1'b1 || o_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL err_lw_22 err=%b rvalid=%b expected 1 0", o_err, o_rvalid);
    end
    issue(1'b1, 2'b01, 1'b0, 10'h033, 32'hFFFF);
    checks++;
    if (o_err !== 1'b1 || o_ready !== 1'b1 || o_wdone !== 1'b0) begin
      errors++;
      $display("FAIL err_sh_33 err=%b ready=%b wdone=%b expected 1 1 0", o_err, o_ready, o_wdone);
    end
    issue(1'b1, 2'b11, 1'b0, 10'h020, 32'h0);
    checks++;
    if (o_err !== 1'b1) begin
      errors++;
      $display("FAIL err_rsvd err=%b expected 1", o_err);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_err !== 1'b0 || we_cnt !== 0 || mem[8] !== 32'hDEADBEEF || mem[12] !== 32'hBEEFAA44) begin
      errors++;
      $display("FAIL err_no_write err=%b we_cycles=%0d mem8=%h mem12=%h expected 0 0 deadbeef beefaa44",
               o_err, we_cnt, mem[8], mem[12]);
    end
  endtask

  task automatic test_reset_midwrite;
    mem[16] = 32'h01020304;
    issue(1'b1, 2'b00, 1'b0, 10'h040, 32'h55);
    checks++;
    if (o_ram_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_we we=%b expected 1", o_ram_we);
    end
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_ram_we !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_we_drop we=%b ready=%b expected 0 1", o_ram_we, o_ready);
    end
    @(posedge i_clk); #1;
    @(negedge i_clk) i_rst = 1'b0;
    #1;
    checks++;
    if (mem[16] !== 32'h01020304 || {o_rvalid, o_wdone, o_err, o_ram_we} !== 4'b0000 || o_rdata !== 32'h0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_after mem=%h rvalid/wdone/err/we=%b rdata=%h ready=%b expected 01020304 0000 0 1",
               mem[16], {o_rvalid, o_wdone, o_err, o_ram_we}, o_rdata, o_ready);
    end
  endtask

`ifdef MEM_ACCESS_STATS_EN
  task automatic test_stats;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    @(negedge i_clk) i_rst = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 10'h020, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 10'h011, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 10'h012, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 10'h024, 32'h1);
    issue(1'b1, 2'b00, 1'b0, 10'h025, 32'h2);
    @(posedge i_clk); #1;
    issue(1'b0, 2'b10, 1'b0, 10'h021, 32'h0);
    @(posedge i_clk); #1;
    checks++;
    if (o_load_cnt !== 32'd3 || o_store_cnt !== 32'd2 || o_err_cnt !== 32'd1) begin
      errors++;
      $display("FAIL stats_counts load=%0d store=%0d err=%0d expected 3 2 1", o_load_cnt, o_store_cnt, o_err_cnt);
    end
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_load_cnt !== 32'd0 || o_store_cnt !== 32'd0 || o_err_cnt !== 32'd0) begin
      errors++;
      $display("FAIL stats_reset load=%0d store=%0d err=%0d expected 0 0 0", o_load_cnt, o_store_cnt, o_err_cnt);
    end
    @(negedge i_clk) i_rst = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset;
    test_loads;
    test_back_to_back;
    test_sw;
    test_subword;
    test_errors;
    test_reset_midwrite;
`ifdef MEM_ACCESS_STATS_EN
    test_stats;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage initiator that drives the single-port word RAM (async read, sync write, 32-bit words) on behalf of the pipeline. Accepts byte/half/word loads and stores on byte addresses and returns registered, sign- or zero-extended load data. Implements sub-word stores as a two-cycle read-merge-write sequence. Flags misaligned accesses without touching the RAM.

Parameters:
ADDR_WIDTH, 8, RAM word-address width; byte address is ADDR_WIDTH+2 bits.

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  asynchronous active-high reset
i_req  in  1  request valid
o_ready  out  1  request accepted when i_req && o_ready
i_we  in  1  1=store, 0=load
i_size  in  2  00 byte, 01 half, 10 word, 11 reserved
i_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
i_addr  in  ADDR_WIDTH+2  byte address
i_wdata  in  32  store data, right-justified
o_rdata  out  32  load result, registered
o_rvalid  out  1  one-cycle pulse, load data valid
o_wdone  out  1  one-cycle pulse, store committed
o_err  out  1  one-cycle pulse, misaligned or reserved-size request dropped
o_ram_addr  out  ADDR_WIDTH  to RAM i_addr
o_ram_data  out  32  to RAM i_data
o_ram_we  out  1  to RAM i_we
i_ram_data  in  32  from RAM o_data (combinational)

Behaviour:
- Endianness: little-endian lanes; byte k = bits[8k+7:8k]; half 0 = [15:0], half 1 = [31:16].
- States: IDLE, WRITE. Reset → IDLE. o_rdata=0, o_rvalid=0, o_wdone=0, o_err=0, merge/address regs=0.
- o_ready = (state==IDLE). o_ram_addr = i_addr[ADDR_WIDTH+1:2] in IDLE, else the latched word address.
- Error check at accept: size 11; half with addr[0]=1; word with addr[1:0]≠0. Error → no RAM write, o_err=1 next cycle, stay IDLE.
- Load (IDLE, accepted): lane selected from i_ram_data and extended, then registered into o_rdata. o_rvalid=1 next cycle. Latency 1. Back-to-back loads every cycle. o_rdata holds its value until the next load.
- SW (IDLE, accepted): o_ram_we=1 and o_ram_data=i_wdata in the same cycle. o_wdone=1 next cycle. Stay IDLE.
- SB/SH (IDLE, accepted): merge i_wdata lane into i_ram_data and latch into r_merge, together with the word address → WRITE.
- WRITE: o_ready=0, o_ram_we=1, o_ram_addr=latched addr, o_ram_data=r_merge. → IDLE. o_wdone=1 in the following cycle. Sub-word store occupancy is 2 cycles.
- o_ram_we is decoded combinationally from state and accept. Outside the write cases it is 0. o_ram_data is 0 when o_ram_we=0.
- A request while in WRITE is not accepted. The requester holds i_req and its fields stable until accepted.
- Async reset mid-WRITE: o_ram_we drops immediately, the pending merge is discarded, pulses clear.
- Address wrap: only word bits used; the top address maps to RAM word 2**ADDR_WIDTH-1. No wrap logic.

Optional Feature:
MEM_ACCESS_STATS_EN: when defined, adds outputs o_load_cnt, o_store_cnt, o_err_cnt (32 bits each).
- Each counter increments once per accepted load, committed store (on o_wdone) or error (on o_err).
- Each counter saturates at 32'hFFFFFFFF and clears on i_rst.
When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package mem_access_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD, state encodings ST_IDLE/ST_WRITE, lane-width constants.
- Sub-module mem_lane_align (combinational):
  - load extract plus sign/zero extend;
  - store merge of a byte/half lane into a word.

Test Plan:
- Preload word 0x4 (byte addr 0x10)=0x80FF7F01. LB 0x11 → 0x0000007F. LB 0x12 → 0xFFFFFFFF. LBU 0x13 → 0x00000080. LH 0x12 → 0xFFFF80FF. Each o_rvalid pulse exactly 1 cycle after accept.
- SW 0x20 ← 0xDEADBEEF, then LW 0x20 → 0xDEADBEEF. o_ram_we high exactly one cycle, o_ready never low.
- Word 0x30=0x11223344. SB 0x31 ← 0xAA → o_ready low 1 cycle, o_ram_we in WRITE, o_wdone next cycle. LW 0x30 → 0x1122AA44. SH 0x32 ← 0xBEEF → 0xBEEFAA44.
- LW 0x22, SH 0x33, size 11 → o_err pulse each, o_ram_we never asserted, RAM unchanged.
- Assert i_rst during WRITE of SB 0x40 ← 0x55 → o_ram_we drops that cycle. After reset, word 0x40 unchanged, all outputs 0, o_ready=1.
- With MEM_ACCESS_STATS_EN: 3 loads, 2 stores, 1 error → counts 3/2/1. Reset → all 0.
